bist_tpg_ctrl: RTL and testbench
================================

BIST_TPG_CTRL -- requirements
Module: bist_tpg_ctrl

Interface
REQ-001 Parameters, one per line:
- SEED, 4'b0001, LFSR start pattern.
- NUM_PATTERNS, 15, patterns applied per run; legal range 1..65535.
- GOLDEN_SIG, 4'b0000, expected signature; the team sets it per CUT.
REQ-002 Ports, one per line:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  run request, level-sampled.
- signature  input  4  MISR output, captured at end of test.
- pattern  output  4  test vector to CUT.
- pattern_valid  output  1  high while pattern is a counted test vector.
- misr_clear  output  1  one-cycle registered pulse to MISR reset.
- busy  output  1  high from CLEAR through COMPARE.
- done  output  1  high in DONE.
- pass  output  1  signature == GOLDEN_SIG, valid when done.
- fail  output  1  signature != GOLDEN_SIG, valid when done.

Function
REQ-003 The LFSR SHALL be 4-bit Fibonacci, polynomial x^4+x^3+1: next = {lfsr[2:0], lfsr[3]^lfsr[2]}, maximal period 15.
REQ-004 SEED of 4'b0000 SHALL be replaced by 4'b0001 (lock-up prevention).
REQ-005 FSM states SHALL be IDLE, CLEAR, RUN, COMPARE, DONE.
REQ-006 IDLE: start=1 -> CLEAR; otherwise stay.
REQ-007 CLEAR, one cycle: misr_clear=1, LFSR loaded with SEED, pattern counter set to 0; -> RUN.
REQ-008 RUN: pattern_valid=1 and pattern=LFSR; LFSR advances and counter increments each cycle.
REQ-009 RUN SHALL last exactly NUM_PATTERNS cycles; when counter==NUM_PATTERNS-1 -> COMPARE.
REQ-010 COMPARE, one cycle: signature captured, pass/fail registers updated; -> DONE.
REQ-011 The capture SHALL be the MISR value that includes the response to the last pattern.
REQ-012 DONE: done=1, pass/fail held; start=1 -> CLEAR (rerun); otherwise stay.
REQ-013 Timing: start sampled at edge 0 -> CLEAR in cycle 1; RUN in cycles 2..NUM_PATTERNS+1; COMPARE in cycle NUM_PATTERNS+2; done from cycle NUM_PATTERNS+3.
REQ-014 start while busy SHALL be ignored.
REQ-015 Outside RUN, pattern SHALL hold its last value and pattern_valid=0.
REQ-016 pass and fail SHALL be mutually exclusive.
REQ-017 pass and fail SHALL both be 0 outside DONE and cleared on entry to CLEAR.
REQ-018 The counter SHALL be 16 bits.
REQ-019 NUM_PATTERNS above 15 SHALL wrap the LFSR sequence with period 15.

Reset
REQ-020 Asserting reset at any time, including mid-RUN, SHALL force IDLE.
REQ-021 Reset values: pattern=SEED (after REQ-004), counter=0; misr_clear, pattern_valid, busy, done, pass and fail all 0.
REQ-022 No output SHALL glitch on reset release.
REQ-023 Reset release SHALL NOT by itself start a run.

Structure
REQ-024 A shared bist_pkg SHALL hold the FSM state enumeration, the LFSR width constant (4) and the tap positions.
REQ-025 The LFSR SHALL be a sub-module bist_lfsr (load, enable, seed in, state out), reusable by other BIST blocks.
REQ-026 The FSM, counter and comparator SHALL reside in bist_tpg_ctrl.

Verification
REQ-027 Reset then start pulse, SEED=0001, NUM_PATTERNS=15 -> pattern sequence 0001, 0010, 0100, 1001, 0011, ... all 15 non-zero values, each once; pattern_valid high exactly 15 cycles.
REQ-028 Bench with a golden model of the CUT and MISR; GOLDEN_SIG set to the model's signature -> done at cycle 18, pass=1, fail=0.
REQ-029 Same run, GOLDEN_SIG with one bit flipped -> fail=1, pass=0.
REQ-030 Reset asserted during RUN at pattern 7, then a fresh start -> IDLE immediately, all outputs at reset values; the rerun restarts from 0001 with misr_clear pulsed.
REQ-031 start held high throughout the run -> no restart while busy; a new run begins in the cycle after DONE is entered.
REQ-032 SEED=0000, NUM_PATTERNS=1 -> single pattern 0001; COMPARE in cycle 3; done in cycle 4.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST blocks: controller state enumeration,
// LFSR width and feedback tap positions, pattern counter width, and a
// helper that keeps an all-zero seed from locking the LFSR up.
package bist_pkg;

   localparam int unsigned LFSR_W = 4;
   // Fibonacci taps for x^4 + x^3 + 1
   localparam int unsigned TAP_A  = 3;
   localparam int unsigned TAP_B  = 2;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_COMPARE,
      ST_DONE
   } bist_state_e;

   // An all-zero LFSR state never leaves zero; substitute the unit pattern.
   function automatic logic [LFSR_W-1:0] safe_seed(input logic [LFSR_W-1:0] s);
      return (s == '0) ? LFSR_W'(1) : s;
   endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR, x^4 + x^3 + 1, maximal period 15.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, loads RESET_STATE
//   load   - load seed (has priority over enable)
//   enable - advance one step
//   seed   - value loaded on load
//   state  - current LFSR state
module bist_lfsr
   import bist_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RESET_STATE = LFSR_W'(1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              enable,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= RESET_STATE;
      end else if (load) begin
         state <= seed;
      end else if (enable) begin
         state <= {state[LFSR_W-2:0], state[TAP_A] ^ state[TAP_B]};
      end
   end

endmodule

// File: rtl/bist_tpg_ctrl.sv
// BIST test-pattern-generator controller. On start it clears the MISR,
// applies NUM_PATTERNS LFSR patterns to the CUT, captures the MISR
// signature and compares it against GOLDEN_SIG.
// Ports:
//   clock         - rising-edge clock
//   reset         - asynchronous active-high reset, forces IDLE
//   start         - run request, sampled in IDLE and DONE only
//   signature     - MISR output, captured in COMPARE
//   pattern       - test vector to the CUT
//   pattern_valid - pattern is a counted test vector (RUN)
//   misr_clear    - one-cycle pulse resetting the MISR (CLEAR)
//   busy          - CLEAR through COMPARE
//   done          - DONE
//   pass / fail   - signature comparison result, valid while done
module bist_tpg_ctrl
   import bist_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED         = 4'b0001,
   parameter int unsigned       NUM_PATTERNS = 15,
   parameter logic [LFSR_W-1:0] GOLDEN_SIG   = 4'b0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [LFSR_W-1:0] signature,
   output logic [LFSR_W-1:0] pattern,
   output logic              pattern_valid,
   output logic              misr_clear,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail
);

   localparam logic [LFSR_W-1:0] SEED_FIX = safe_seed(SEED);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

   bist_state_e      state_q;
   bist_state_e      state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             run_last;
   logic             lfsr_load;
   logic             lfsr_enable;

   assign run_last = (cnt_q == LAST_CNT);

   // The LFSR does not step on the final RUN cycle so that pattern keeps
   // showing the last applied vector through COMPARE and DONE.
   assign lfsr_load   = (state_q == ST_CLEAR);
   assign lfsr_enable = (state_q == ST_RUN) && !run_last;

   bist_lfsr #(
      .RESET_STATE (SEED_FIX)
   ) u_lfsr (
      .clock  (clock),
      .reset  (reset),
      .load   (lfsr_load),
      .enable (lfsr_enable),
      .seed   (SEED_FIX),
      .state  (pattern)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_CLEAR;
         ST_CLEAR:   state_d = ST_RUN;
         ST_RUN:     if (run_last) state_d = ST_COMPARE;
         ST_COMPARE: state_d = ST_DONE;
         ST_DONE:    if (start) state_d = ST_CLEAR;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (state_q == ST_CLEAR) begin
         cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Status outputs are registered from the next state so they are flop
   // outputs aligned with the state they describe, free of decode glitches.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pattern_valid <= 1'b0;
         misr_clear    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         pattern_valid <= (state_d == ST_RUN);
         misr_clear    <= (state_d == ST_CLEAR);
         busy          <= (state_d == ST_CLEAR) || (state_d == ST_RUN) ||
                          (state_d == ST_COMPARE);
         done          <= (state_d == ST_DONE);
      end
   end

   // The signature seen during COMPARE already includes the MISR update
   // from the last RUN cycle; the result is visible from DONE onward.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pass <= 1'b0;
         fail <= 1'b0;
      end else if (state_q == ST_COMPARE) begin
         pass <= (signature == GOLDEN_SIG);
         fail <= (signature != GOLDEN_SIG);
      end else if (state_d == ST_CLEAR) begin
         pass <= 1'b0;
         fail <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bist_tpg_ctrl.sv
module tb_bist_tpg_ctrl;

   logic clock = 1'b0;
   logic reset;
   logic start;

   always #5 clock = ~clock;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Maximal-length x^4+x^3+1 sequence starting from 0001.
   function automatic logic [3:0] tbl(input int unsigned i);
      case (i)
         0: return 4'h1;   1: return 4'h2;   2: return 4'h4;   3: return 4'h9;
         4: return 4'h3;   5: return 4'h6;   6: return 4'hD;   7: return 4'hA;
         8: return 4'h5;   9: return 4'hB;  10: return 4'h7;  11: return 4'hF;
        12: return 4'hE;  13: return 4'hC;  14: return 4'h8;
         default: return 4'h1;
      endcase
   endfunction

   // Seed 0 is not in the table, so it maps to position 0 (pattern 0001).
   function automatic int unsigned idx_of(input logic [3:0] s);
      for (int unsigned i = 0; i < 15; i++) if (tbl(i) == s) return i;
      return 0;
   endfunction

   function automatic logic [3:0] seq_at(input logic [3:0] seed, input int unsigned k);
      return tbl((idx_of(seed) + k) % 15);
   endfunction

   function automatic logic [3:0] cut(input logic [3:0] p);
      int v;
      v = int'(p);
      return 4'((v * 7 + 3) % 16);
   endfunction

   function automatic logic [3:0] misr_step(input logic [3:0] m, input logic [3:0] r);
      return {m[2:0], m[3] ^ m[2]} ^ r;
   endfunction

   function automatic logic [3:0] model_sig(input logic [3:0] seed, input int unsigned n);
      logic [3:0] m;
      m = 4'h0;
      for (int unsigned k = 0; k < n; k++) m = misr_step(m, cut(seq_at(seed, k)));
      return m;
   endfunction

   localparam logic [3:0] G0 = model_sig(4'h1, 15);
   localparam logic [3:0] G1 = G0 ^ 4'b0100;
   localparam logic [3:0] G2 = model_sig(4'h0, 1);
   localparam logic [3:0] G3 = model_sig(4'h9, 20);

   logic [3:0]  SD [4] = '{4'h1, 4'h1, 4'h0, 4'h9};
   int unsigned NN [4] = '{15, 15, 1, 20};
   logic [3:0]  GD [4] = '{G0, G1, G2, G3};
   logic        EP [4];

   logic [3:0] pat  [4];
   logic       val  [4];
   logic       clr  [4];
   logic       bsy  [4];
   logic       dn   [4];
   logic       ps   [4];
   logic       fl   [4];
   logic [3:0] misr [4];

   bist_tpg_ctrl #(.SEED(4'h1), .NUM_PATTERNS(15), .GOLDEN_SIG(G0)) u0 (
      .clock(clock), .reset(reset), .start(start), .signature(misr[0]),
      .pattern(pat[0]), .pattern_valid(val[0]), .misr_clear(clr[0]),
      .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .fail(fl[0]));
   bist_tpg_ctrl #(.SEED(4'h1), .NUM_PATTERNS(15), .GOLDEN_SIG(G1)) u1 (
      .clock(clock), .reset(reset), .start(start), .signature(misr[1]),
      .pattern(pat[1]), .pattern_valid(val[1]), .misr_clear(clr[1]),
      .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .fail(fl[1]));
   bist_tpg_ctrl #(.SEED(4'h0), .NUM_PATTERNS(1), .GOLDEN_SIG(G2)) u2 (
      .clock(clock), .reset(reset), .start(start), .signature(misr[2]),
      .pattern(pat[2]), .pattern_valid(val[2]), .misr_clear(clr[2]),
      .busy(bsy[2]), .done(dn[2]), .pass(ps[2]), .fail(fl[2]));
   bist_tpg_ctrl #(.SEED(4'h9), .NUM_PATTERNS(20), .GOLDEN_SIG(G3)) u3 (
      .clock(clock), .reset(reset), .start(start), .signature(misr[3]),
      .pattern(pat[3]), .pattern_valid(val[3]), .misr_clear(clr[3]),
      .busy(bsy[3]), .done(dn[3]), .pass(ps[3]), .fail(fl[3]));

   // CUT + MISR behavioural model, one per DUT.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) misr[i] <= 4'h0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (clr[i])      misr[i] <= 4'h0;
            else if (val[i]) misr[i] <= misr_step(misr[i], cut(pat[i]));
         end
      end
   end

   // Timeline model: rel = cycles since start was accepted (0 = idle).
   // rel 1 clear, 2..N+1 run, N+2 compare, >= N+3 done.
   int unsigned rel [4];
   logic [3:0]  lp  [4];

   task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         rel[i] = 0;
         lp[i]  = seq_at(SD[i], 0);
      end
   endtask

   task automatic model_step(input logic st);
      for (int i = 0; i < 4; i++) begin
         if (rel[i] == 0 || rel[i] >= NN[i] + 3) begin
            if (st) begin
               if (rel[i] != 0) lp[i] = seq_at(SD[i], NN[i] - 1);
               rel[i] = 1;
            end else if (rel[i] != 0) begin
               rel[i] = rel[i] + 1;
            end
         end else begin
            rel[i] = rel[i] + 1;
         end
      end
   endtask

   task automatic model_check();
      for (int i = 0; i < 4; i++) begin
         int unsigned r, n;
         logic [3:0] ep;
         logic ev, ec, eb, ed;
         r  = rel[i];
         n  = NN[i];
         ev = (r >= 2) && (r <= n + 1);
         ec = (r == 1);
         eb = (r >= 1) && (r <= n + 2);
         ed = (r >= n + 3);
         if (r <= 1)          ep = lp[i];
         else if (r <= n + 1) ep = seq_at(SD[i], r - 2);
         else                 ep = seq_at(SD[i], n - 1);
         chk4($sformatf("u%0d.pattern", i), pat[i], ep);
         chk1($sformatf("u%0d.pattern_valid", i), val[i], ev);
         chk1($sformatf("u%0d.misr_clear", i), clr[i], ec);
         chk1($sformatf("u%0d.busy", i), bsy[i], eb);
         chk1($sformatf("u%0d.done", i), dn[i], ed);
         chk1($sformatf("u%0d.pass", i), ps[i], ed && EP[i]);
         chk1($sformatf("u%0d.fail", i), fl[i], ed && !EP[i]);
      end
   endtask

   // Called just after a falling edge: drive, take a rising edge, check.
   task automatic tick(input logic st, input logic rs);
      start = st;
      reset = rs;
      @(posedge clock);
      if (rs) model_reset();
      else    model_step(st);
      @(negedge clock);
      model_check();
   endtask

   typedef struct {
      logic       start;
      logic [3:0] pat;
      logic [4:0] fl;   // {valid, clear, busy, done, pass}
   } vec_t;

   vec_t tv [19];

   task automatic add(input int unsigned k, input logic s, input logic [3:0] p,
                      input logic [4:0] f);
      tv[k].start = s;
      tv[k].pat   = p;
      tv[k].fl    = f;
   endtask

   initial begin
      logic [15:0] seen;
      int unsigned vcount;

      add( 0, 1'b1, 4'h1, 5'b01100);
      add( 1, 1'b0, 4'h1, 5'b10100);
      add( 2, 1'b0, 4'h2, 5'b10100);
      add( 3, 1'b0, 4'h4, 5'b10100);
      add( 4, 1'b0, 4'h9, 5'b10100);
      add( 5, 1'b0, 4'h3, 5'b10100);
      add( 6, 1'b0, 4'h6, 5'b10100);
      add( 7, 1'b0, 4'hD, 5'b10100);
      add( 8, 1'b0, 4'hA, 5'b10100);
      add( 9, 1'b0, 4'h5, 5'b10100);
      add(10, 1'b0, 4'hB, 5'b10100);
      add(11, 1'b0, 4'h7, 5'b10100);
      add(12, 1'b0, 4'hF, 5'b10100);
      add(13, 1'b0, 4'hE, 5'b10100);
      add(14, 1'b0, 4'hC, 5'b10100);
      add(15, 1'b0, 4'h8, 5'b10100);
      add(16, 1'b0, 4'h8, 5'b00100);
      add(17, 1'b0, 4'h8, 5'b00011);
      add(18, 1'b0, 4'h8, 5'b00011);

      for (int i = 0; i < 4; i++) EP[i] = (model_sig(SD[i], NN[i]) == GD[i]);

      // Reset values.
      reset = 1'b1;
      start = 1'b0;
      model_reset();
      @(negedge clock);
      tick(1'b0, 1'b1);
      chk4("rst_u0_pattern", pat[0], 4'h1);
      chk4("rst_u2_pattern_zero_seed", pat[2], 4'h1);
      chk4("rst_u3_pattern", pat[3], 4'h9);

      // Reset release alone must not start a run.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);

      // Table-driven first run.
      seen   = '0;
      vcount = 0;
      for (int k = 0; k < 19; k++) begin
         tick(tv[k].start, 1'b0);
         chk4("tbl_pattern", pat[0], tv[k].pat);
         chk1("tbl_valid", val[0], tv[k].fl[4]);
         chk1("tbl_clear", clr[0], tv[k].fl[3]);
         chk1("tbl_busy", bsy[0], tv[k].fl[2]);
         chk1("tbl_done", dn[0], tv[k].fl[1]);
         chk1("tbl_pass", ps[0], tv[k].fl[0]);
         chk1("tbl_u1_fail", fl[1], tv[k].fl[0]);
         chk1("tbl_u1_pass", ps[1], 1'b0);
         if (val[0]) begin
            seen[pat[0]] = 1'b1;
            vcount++;
         end
         if (k == 1) begin
            chk4("n1_pattern", pat[2], 4'h1);
            chk1("n1_valid", val[2], 1'b1);
         end
         if (k == 2) begin
            chk1("n1_compare_busy", bsy[2], 1'b1);
            chk1("n1_compare_done", dn[2], 1'b0);
         end
         if (k == 3) begin
            chk1("n1_done", dn[2], 1'b1);
            chk1("n1_pass", ps[2], 1'b1);
         end
      end
      chk4("valid_cycles", 4'(vcount), 4'd15);
      checks++;
      if (seen !== 16'hFFFE) begin
         errors++;
         $display("FAIL pattern_coverage: got %h expected fffe", seen);
      end

      // start held high: ignored while busy, rerun right after DONE.
      for (int j = 1; j <= 19; j++) begin
         tick(1'b1, 1'b0);
         chk1("hold_clear", clr[0], (j == 1) || (j == 19));
         chk1("hold_done", dn[0], j == 18);
         chk1("hold_busy", bsy[0], j != 18);
      end

      // Reset in the middle of RUN at the 7th pattern.
      for (int j = 0; j < 7; j++) tick(1'b0, 1'b0);
      chk4("mid_pattern7", pat[0], 4'hD);
      reset = 1'b1;
      #1;
      chk4("mid_rst_pattern", pat[0], 4'h1);
      chk1("mid_rst_valid", val[0], 1'b0);
      chk1("mid_rst_clear", clr[0], 1'b0);
      chk1("mid_rst_busy", bsy[0], 1'b0);
      chk1("mid_rst_done", dn[0], 1'b0);
      chk1("mid_rst_pass", ps[0], 1'b0);
      chk1("mid_rst_fail", fl[0], 1'b0);
      model_reset();
      @(negedge clock);
      model_check();
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      chk1("rerun_clear", clr[0], 1'b1);
      tick(1'b0, 1'b0);
      chk4("rerun_first", pat[0], 4'h1);
      chk1("rerun_valid", val[0], 1'b1);

      // Randomized start/reset traffic against the model.
      for (int j = 0; j < 400; j++) begin
         tick($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
